// File: rtl/pof_stream_pkg.sv
// Shared types and arithmetic helpers for the pof stream blocks.
package pof_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } win_state_t;

    // Signed overflow from operand and result sign bits, so it works at any width.
    function automatic logic signed_add_ovf(input logic a_sign,
                                            input logic b_sign,
                                            input logic sum_sign);
        return (a_sign == b_sign) && (sum_sign != a_sign);
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] count,
                                            input logic [63:0] max_val);
        return (count >= max_val) ? max_val : count + 64'd1;
    endfunction

endpackage

// File: rtl/stream_result_reg.sv
// Single-entry result holding register; owns result-valid and the upstream ready equation.
module stream_result_reg #(
    parameter int ACC_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [ACC_WIDTH-1:0]   data_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic                   ovf_i,
    input  logic                   rtr_i,
    output logic                   ready_o,
    output logic                   rts_o,
    output logic [ACC_WIDTH-1:0]   data_o,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   ovf_o
);

    logic                   rts_q,   rts_d;
    logic [ACC_WIDTH-1:0]   data_q,  data_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q,   ovf_d;

    // A load can only arrive when ready_o is high, so it never overwrites a held result.
    assign ready_o = ~rts_q | rtr_i;

    always_comb begin
        rts_d   = load_i | (rts_q & ~rtr_i);
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (load_i) begin
            data_d  = data_i;
            count_d = count_i;
            ovf_d   = ovf_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_q   <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rts_q   <= rts_d;
            data_q  <= data_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rts_o   = rts_q;
    assign data_o  = data_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/stream_window_accumulator.sv
// Sums signed beats from sow to eow inclusive and emits one {sum, count, ovf} result per window.
//   state | meaning
//   IDLE  | no window open; only a sow beat is legal
//   ACCUM | window open; accumulating until eow
module stream_window_accumulator
    import pof_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   rtr_o,
    input  logic                   rts_i,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [ACC_WIDTH-1:0]   data_o,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   ovf_o,
    output logic                   err_o
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    win_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic                   flag_q,  flag_d;
    logic                   err_q,   err_d;

    logic                   accept;
    logic [ACC_WIDTH-1:0]   ext;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   ovf_beat;
    logic [COUNT_WIDTH-1:0] cnt_inc;

    logic                   load;
    logic [ACC_WIDTH-1:0]   res_data;
    logic [COUNT_WIDTH-1:0] res_cnt;
    logic                   res_ovf;

    assign accept   = rts_i & rtr_o;
    assign ext      = ACC_WIDTH'($signed(data_i));
    assign sum      = acc_q + ext;
    assign ovf_beat = signed_add_ovf(acc_q[ACC_WIDTH-1], ext[ACC_WIDTH-1], sum[ACC_WIDTH-1]);
    assign cnt_inc  = COUNT_WIDTH'(sat_inc(64'(cnt_q), 64'(CNT_MAX)));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;
        err_d    = err_q;
        load     = 1'b0;
        res_data = sum;
        res_cnt  = cnt_inc;
        res_ovf  = flag_q | ovf_beat;
        if (accept) begin
            if (sow_i) begin
                // A sow inside an open window abandons it and restarts from this beat.
                if (state_q == ACCUM) begin
                    err_d = 1'b1;
                end
                if (eow_i) begin
                    load     = 1'b1;
                    res_data = ext;
                    res_cnt  = CNT_ONE;
                    res_ovf  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    acc_d   = ext;
                    cnt_d   = CNT_ONE;
                    flag_d  = 1'b0;
                    state_d = ACCUM;
                end
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else if (eow_i) begin
                load    = 1'b1;
                state_d = IDLE;
            end else begin
                acc_d  = sum;
                cnt_d  = cnt_inc;
                flag_d = flag_q | ovf_beat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
        end
    end

    stream_result_reg #(
        .ACC_WIDTH   (ACC_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_result (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .data_i  (res_data),
        .count_i (res_cnt),
        .ovf_i   (res_ovf),
        .rtr_i   (rtr_i),
        .ready_o (rtr_o),
        .rts_o   (rts_o),
        .data_o  (data_o),
        .count_o (count_o),
        .ovf_o   (ovf_o)
    );

    assign sow_o = rts_o;
    assign eow_o = rts_o;
    assign err_o = err_q;

endmodule

// File: tb/tb_stream_window_accumulator.sv
// Self-checking bench: vector table, directed corner sequences, and random traffic against a window model.
module tb_stream_window_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rtr_o, rts_i, sow_i, eow_i, rtr_i;
    logic [15:0] data_i;
    logic        rts_o, sow_o, eow_o, ovf_o, err_o;
    logic [31:0] data_o;
    logic [15:0] count_o;

    logic        o_rtr_o, o_rts_i, o_sow_i, o_eow_i, o_rtr_i;
    logic [15:0] o_data_i;
    logic        o_rts_o, o_sow_o, o_eow_o, o_ovf_o, o_err_o;
    logic [15:0] o_data_o;
    logic [1:0]  o_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_window_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .COUNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .sow_i(sow_i), .eow_i(eow_i),
        .data_i(data_i), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
        .data_o(data_o), .count_o(count_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    stream_window_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .COUNT_WIDTH(2)) u_ovf (
        .clk(clk), .rst_n(rst_n), .rtr_o(o_rtr_o), .rts_i(o_rts_i), .sow_i(o_sow_i), .eow_i(o_eow_i),
        .data_i(o_data_i), .rtr_i(o_rtr_i), .rts_o(o_rts_o), .sow_o(o_sow_o), .eow_o(o_eow_o),
        .data_o(o_data_o), .count_o(o_count_o), .ovf_o(o_ovf_o), .err_o(o_err_o)
    );

    typedef struct {
        logic        vld, sow, eow;
        logic [15:0] d;
        logic        rdy;
        logic        e_rts;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
        logic        e_ovf, e_err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [15:0] c;
        logic        o;
    } res_t;

    vec_t tbl[$];
    res_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, s, e, input int d, input logic r,
                                input logic er, input logic [31:0] ed, input int ec,
                                input logic eo, ee);
        vec_t t;
        t.vld = v; t.sow = s; t.eow = e; t.d = 16'(d); t.rdy = r;
        t.e_rts = er; t.e_data = ed; t.e_cnt = 16'(ec); t.e_ovf = eo; t.e_err = ee;
        return t;
    endfunction

    task automatic drv(input logic v, s, e, input int d, input logic r);
        @(negedge clk);
        rts_i = v; sow_i = s; eow_i = e; data_i = 16'(d); rtr_i = r;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic odrv(input logic v, s, e, input int d);
        @(negedge clk);
        o_rts_i = v; o_sow_i = s; o_eow_i = e; o_data_i = 16'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rts_i = 0; sow_i = 0; eow_i = 0; data_i = 0; rtr_i = 1;
        rst_n = 0;
        #3;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Window model: plain integer arithmetic, wrapping to 32 bits only when stored.
    bit     m_open;
    longint m_acc;
    int     m_cnt;
    bit     m_ovf;
    bit     m_err;

    function automatic longint wrap32(input longint t);
        logic [31:0] w;
        w = t[31:0];
        return longint'($signed(w));
    endfunction

    task automatic model_beat(input logic s, e, input logic [15:0] d);
        longint ext, t;
        res_t r;
        ext = longint'($signed(d));
        if (s) begin
            if (m_open) m_err = 1;
            if (e) begin
                r.d = ext[31:0]; r.c = 16'd1; r.o = 1'b0;
                exp_q.push_back(r);
                m_open = 0;
            end else begin
                m_open = 1; m_acc = ext; m_cnt = 1; m_ovf = 0;
            end
        end else if (!m_open) begin
            m_err = 1;
        end else begin
            t = m_acc + ext;
            m_ovf = m_ovf | (t > 64'sd2147483647) | (t < -64'sd2147483648);
            m_acc = wrap32(t);
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (e) begin
                r.d = m_acc[31:0]; r.c = 16'(m_cnt); r.o = m_ovf;
                exp_q.push_back(r);
                m_open = 0;
            end
        end
    endtask

    initial begin
        rts_i = 0; sow_i = 0; eow_i = 0; data_i = 0; rtr_i = 1;
        o_rts_i = 0; o_sow_i = 0; o_eow_i = 0; o_data_i = 0; o_rtr_i = 1;
        #12;
        chk("reset_rts", rts_o, 0);
        chk("reset_data", data_o, 0);
        chk("reset_count", count_o, 0);
        chk("reset_ovf", ovf_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_rtr", rtr_o, 1);
        @(negedge clk);
        rst_n = 1;

        // Overflow and count saturation on the 16-bit accumulator / 2-bit counter instance.
        odrv(1, 1, 0, 16'h7FFF);
        odrv(1, 0, 1, 16'h0001);
        chk("ovf_pos_rts", o_rts_o, 1);
        chk("ovf_pos_data", o_data_o, 16'h8000);
        chk("ovf_pos_flag", o_ovf_o, 1);
        chk("ovf_pos_count", o_count_o, 2);
        odrv(1, 1, 0, 1);
        odrv(1, 0, 1, 2);
        chk("ovf_clean_data", o_data_o, 3);
        chk("ovf_clean_flag", o_ovf_o, 0);
        odrv(1, 1, 0, 16'h8000);
        odrv(1, 0, 1, 16'hFFFF);
        chk("ovf_neg_data", o_data_o, 16'h7FFF);
        chk("ovf_neg_flag", o_ovf_o, 1);
        odrv(1, 1, 0, 1);
        repeat (3) odrv(1, 0, 0, 1);
        odrv(1, 0, 1, 1);
        chk("sat_data", o_data_o, 5);
        chk("sat_count", o_count_o, 3);
        chk("sat_ovf", o_ovf_o, 0);
        odrv(0, 0, 0, 0);
        chk("sat_rts_clear", o_rts_o, 0);
        chk("ovf_inst_err", o_err_o, 0);

        // Per-cycle vectors: {vld sow eow data rdy} -> outputs after the edge.
        tbl.push_back(mk(1, 1, 0, 5,    1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, -2,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 10,   1, 1, 32'd13, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, -7,   1, 1, 32'hFFFFFFF9, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, -100, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, -200, 1, 1, 32'hFFFFFED4, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 20,   0, 1, 32'd20, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 1, 32'd20, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    1, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drv(tbl[i].vld, tbl[i].sow, tbl[i].eow, int'($signed(tbl[i].d)), tbl[i].rdy);
            edge_wait();
            chk($sformatf("vec%0d_rts", i), rts_o, tbl[i].e_rts);
            chk($sformatf("vec%0d_sow_eow", i), {sow_o, eow_o}, {2{tbl[i].e_rts}});
            chk($sformatf("vec%0d_err", i), err_o, tbl[i].e_err);
            if (tbl[i].e_rts) begin
                chk($sformatf("vec%0d_data", i), data_o, tbl[i].e_data);
                chk($sformatf("vec%0d_count", i), count_o, tbl[i].e_cnt);
                chk($sformatf("vec%0d_ovf", i), ovf_o, tbl[i].e_ovf);
            end
        end

        // Back-pressure: a held result stalls the next window, nothing lost or duplicated.
        do_reset();
        drv(1, 1, 0, 4, 1); edge_wait();
        drv(1, 0, 1, 6, 0); edge_wait();
        chk("bp_first_rts", rts_o, 1);
        chk("bp_first_data", data_o, 10);
        repeat (2) begin
            drv(1, 1, 0, 1, 0);
            #1 chk("bp_stall_rtr", rtr_o, 0);
            edge_wait();
            chk("bp_hold_rts", rts_o, 1);
            chk("bp_hold_data", data_o, 10);
        end
        drv(1, 1, 0, 1, 1);
        #1 chk("bp_release_rtr", rtr_o, 1);
        edge_wait();
        chk("bp_taken_rts", rts_o, 0);
        drv(1, 0, 1, 1, 0);
        #1 chk("bp_eow_rtr", rtr_o, 1);
        edge_wait();
        chk("bp_second_rts", rts_o, 1);
        chk("bp_second_data", data_o, 2);
        chk("bp_second_count", count_o, 2);
        drv(0, 0, 0, 0, 1); edge_wait();
        chk("bp_no_dup", rts_o, 0);
        chk("bp_err", err_o, 0);

        // Stray beat while idle is dropped.
        do_reset();
        drv(1, 0, 1, 3, 1); edge_wait();
        chk("stray_err", err_o, 1);
        chk("stray_rts", rts_o, 0);
        drv(0, 0, 0, 0, 1); edge_wait();
        chk("stray_no_result", rts_o, 0);

        // sow inside an open window restarts it.
        do_reset();
        drv(1, 1, 0, 3, 1); edge_wait();
        drv(1, 0, 0, 4, 1); edge_wait();
        chk("restart_err_before", err_o, 0);
        drv(1, 1, 0, 9, 1); edge_wait();
        chk("restart_err", err_o, 1);
        chk("restart_no_result", rts_o, 0);
        drv(1, 0, 1, 1, 1); edge_wait();
        chk("restart_rts", rts_o, 1);
        chk("restart_data", data_o, 10);
        chk("restart_count", count_o, 2);
        drv(0, 0, 0, 0, 1); edge_wait();
        chk("restart_single", rts_o, 0);

        // Asynchronous reset with a pending result, then with an open window.
        drv(1, 1, 0, 7, 1); edge_wait();
        drv(1, 0, 1, 8, 0); edge_wait();
        chk("rst_pending_rts", rts_o, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_async_rts", rts_o, 0);
        chk("rst_async_err", err_o, 0);
        chk("rst_async_data", data_o, 0);
        @(negedge clk);
        rts_i = 0; rtr_i = 1;
        rst_n = 1;
        drv(1, 1, 0, 100, 1); edge_wait();
        #2 rst_n = 0;
        #1 chk("rst_open_rts", rts_o, 0);
        @(negedge clk);
        rts_i = 0;
        rst_n = 1;
        drv(1, 1, 0, 2, 1); edge_wait();
        drv(1, 0, 1, 3, 1); edge_wait();
        chk("rst_after_data", data_o, 5);
        chk("rst_after_count", count_o, 2);
        chk("rst_after_err", err_o, 0);

        // Random traffic against the window model.
        do_reset();
        m_open = 0; m_acc = 0; m_cnt = 0; m_ovf = 0; m_err = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic v, s, e, r, exp_rts;
            logic [15:0] d;
            v = ($urandom_range(0, 9) < 7);
            s = m_open ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 9);
            e = ($urandom_range(0, 9) < 3);
            d = 16'($urandom);
            r = ($urandom_range(0, 3) != 0);
            drv(v, s, e, int'($signed(d)), r);
            #1;
            exp_rts = (exp_q.size() != 0);
            chk("rnd_rtr", rtr_o, !exp_rts | r);
            chk("rnd_rts", rts_o, exp_rts);
            chk("rnd_err", err_o, m_err);
            if (exp_rts) begin
                chk("rnd_data", data_o, exp_q[0].d);
                chk("rnd_count", count_o, exp_q[0].c);
                chk("rnd_ovf", ovf_o, exp_q[0].o);
                if (r) void'(exp_q.pop_front());
            end
            if (v && (!exp_rts || r)) model_beat(s, e, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
